instruction_memory: RTL and testbench

Read-only instruction store for the RISC-V instruction fetch unit. It takes the byte address held in the program counter and returns the 32-bit instruction stored there. The boot program is fixed in hardware. Sits between the PC register and the decode stage.

---
 rtl/instruction_memory_pkg.sv | 51 +++++
 rtl/instruction_memory_rom.sv | 30 +++
 rtl/instruction_memory.sv | 41 ++++
 tb/tb_instruction_memory.sv | 108 ++++++++++
 4 files changed

// File: rtl/instruction_memory_pkg.sv
// Shared constants for the instruction fetch ROM: the fixed boot program
// and helpers that expose it as a little-endian byte image.
package instruction_memory_pkg;

  localparam int unsigned PROG_WORDS = 8;
  localparam int unsigned PROG_BYTES = PROG_WORDS * 4;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [31:0] BOOT_W0 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] BOOT_W1 = 32'h00A0_0113;  // addi x2,x0,10
  localparam logic [31:0] BOOT_W2 = 32'h0020_81B3;  // add  x3,x1,x2
  localparam logic [31:0] BOOT_W3 = 32'h4020_8233;  // sub  x4,x1,x2
  localparam logic [31:0] BOOT_W4 = 32'h0020_F2B3;  // and  x5,x1,x2
  localparam logic [31:0] BOOT_W5 = 32'h0020_E333;  // or   x6,x1,x2
  localparam logic [31:0] BOOT_W6 = 32'h0020_C3B3;  // xor  x7,x1,x2
  localparam logic [31:0] BOOT_W7 = NOP;

  function automatic logic [31:0] boot_word(input logic [2:0] idx);
    logic [31:0] w;
    case (idx)
      3'd0:    w = BOOT_W0;
      3'd1:    w = BOOT_W1;
      3'd2:    w = BOOT_W2;
      3'd3:    w = BOOT_W3;
      3'd4:    w = BOOT_W4;
      3'd5:    w = BOOT_W5;
      3'd6:    w = BOOT_W6;
      default: w = BOOT_W7;
    endcase
    return w;
  endfunction

  // Byte image of the ROM; everything past the boot program reads as zero.
  function automatic logic [7:0] boot_byte(input int unsigned addr);
    logic [4:0]  a;
    logic [31:0] w;
    logic [7:0]  b;
    a = addr[4:0];
    w = boot_word(a[4:2]);
    case (a[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    if (addr >= PROG_BYTES) b = 8'h00;
    return b;
  endfunction

endpackage

// File: rtl/instruction_memory_rom.sv
// Combinational byte-array ROM returning the little-endian word at a word index.
module instruction_memory_rom
  import instruction_memory_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic [ADDR_W-3:0] word_addr,
  output logic [31:0]       word
);

  logic [7:0] mem [MEM_BYTES];

  for (genvar i = 0; i < MEM_BYTES; i++) begin : g_byte
    assign mem[i] = boot_byte(i);
  end

  logic [ADDR_W-1:0] addr_b0;
  logic [ADDR_W-1:0] addr_b1;
  logic [ADDR_W-1:0] addr_b2;
  logic [ADDR_W-1:0] addr_b3;

  assign addr_b0 = {word_addr, 2'b00};
  assign addr_b1 = {word_addr, 2'b01};
  assign addr_b2 = {word_addr, 2'b10};
  assign addr_b3 = {word_addr, 2'b11};

  assign word = {mem[addr_b3], mem[addr_b2], mem[addr_b1], mem[addr_b0]};

endmodule

// File: rtl/instruction_memory.sv
// Instruction fetch ROM: word-aligned, wrapping PC lookup with a one-cycle
// registered output that clears asynchronously while RESET is low.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned ADDR_W    = $clog2(MEM_BYTES)
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] PC,
  output logic [31:0] INST_CODE
);

  // Low two bits force word alignment; high bits wrap modulo MEM_BYTES.
  logic [ADDR_W-3:0] word_addr_p0;
  logic [31:0]       word_p0;
  logic              unused_pc_bits;

  assign word_addr_p0   = PC[ADDR_W-1:2];
  assign unused_pc_bits = ^{PC[31:ADDR_W], PC[1:0]};

  instruction_memory_rom #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_rom (
    .word_addr (word_addr_p0),
    .word      (word_p0)
  );

  // p0 -> p1: registered fetch result
  logic [31:0] inst_p1;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) inst_p1 <= '0;
    else        inst_p1 <= word_p0;
  end

  assign INST_CODE = inst_p1;

endmodule

// File: tb/tb_instruction_memory.sv
// Bench for instruction_memory: directed boot-program fetches, wrap/misalign
// cases, async reset, then randomized PCs against a byte-array model.
module tb_instruction_memory;

  localparam int unsigned MEM_BYTES = 64;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] inst_code;

  int n_tests;
  int n_fail;

  instruction_memory #(.MEM_BYTES(MEM_BYTES)) dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .PC        (pc),
    .INST_CODE (inst_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  model_mem [MEM_BYTES];
  logic [31:0] prog [8] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40208233,
                            32'h0020F2B3, 32'h0020E333, 32'h0020C3B3, 32'h00000013};

  function automatic logic [31:0] ref_fetch(input logic [31:0] addr);
    int unsigned a;
    a = (addr % MEM_BYTES) / 4 * 4;
    return {model_mem[a+3], model_mem[a+2], model_mem[a+1], model_mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive PC after a falling edge, let one rising edge load it, check at next falling edge.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    pc = addr;
    @(posedge clk);
    @(negedge clk);
    chk(tag, inst_code, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < int'(MEM_BYTES); i++) model_mem[i] = 8'h00;
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 4; b++) model_mem[w*4+b] = prog[w][8*b +: 8];

    rst_n = 1'b0;
    pc    = 32'h4;
    #1;
    chk("reset_t0", inst_code, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_hold", inst_code, 32'h0);
    end

    rst_n = 1'b1;
    fetch("seq_0",      32'h0,        32'h00500093);
    fetch("seq_4",      32'h4,        32'h00A00113);
    fetch("seq_8",      32'h8,        32'h002081B3);
    fetch("seq_c",      32'hC,        32'h40208233);
    fetch("misalign_b", 32'h0000000B, 32'h002081B3);
    fetch("wrap_40",    32'h00000040, 32'h00500093);
    fetch("wrap_hi",    32'hFFFFFFDC, 32'h00000013);
    fetch("blank_20",   32'h20,       32'h00000000);
    fetch("blank_3c",   32'h3C,       32'h00000000);
    fetch("seq_14",     32'h14,       32'h0020E333);

    #2 rst_n = 1'b0;
    #1 chk("mid_reset_async", inst_code, 32'h0);
    pc = 32'h18;
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_held", inst_code, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("resume_18", inst_code, 32'h0020C3B3);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(15) == 0) r = r & 32'h0000003F;
      fetch("rand", r, ref_fetch(r));
      if ($urandom_range(19) == 0) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_reset", inst_code, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
